// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the floating-point adder control path:
// sequencer states, width constants and the one-hot stage-enable encoding.
package fp_ctrl_pkg;

    localparam int FP_DATA_WIDTH = 32;
    localparam int FP_MENT_WIDTH = 23;
    localparam int FP_EXPO_WIDTH = 8;

    // Largest useful alignment shift: past {carry, hidden, fraction} everything is shifted out.
    localparam int SHIFT_SAT = FP_MENT_WIDTH + 2;
    localparam int POS_WIDTH = $clog2(FP_MENT_WIDTH + 2) + 1;

    typedef enum logic [2:0] {
        IDLE,
        EXP_CMP,
        ALIGN,
        MANT_ADD,
        NORMALIZE,
        DONE
    } state_t;

    localparam logic [3:0] STAGE_NONE      = 4'b0000;
    localparam logic [3:0] STAGE_EXP_CMP   = 4'b0001;
    localparam logic [3:0] STAGE_ALIGN     = 4'b0010;
    localparam logic [3:0] STAGE_MANT_ADD  = 4'b0100;
    localparam logic [3:0] STAGE_NORMALIZE = 4'b1000;

    function automatic logic [3:0] stage_enable(input state_t s);
        case (s)
            EXP_CMP:   return STAGE_EXP_CMP;
            ALIGN:     return STAGE_ALIGN;
            MANT_ADD:  return STAGE_MANT_ADD;
            NORMALIZE: return STAGE_NORMALIZE;
            default:   return STAGE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fp_add_sequencer_if.sv
// Operand-in and result-out valid/ready handshakes of the adder sequencer.
// master = upstream producer / downstream consumer side, slave = the sequencer.
interface fp_add_sequencer_if
    import fp_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = FP_DATA_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] floating1_in;
    logic [DATA_WIDTH-1:0] floating2_in;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_valid, floating1_in, floating2_in, out_ready,
        input  in_ready, out_valid
    );

    modport slave (
        input  in_valid, floating1_in, floating2_in, out_ready,
        output in_ready, out_valid
    );
endinterface

// File: rtl/fp_lead_one_detector.sv
// MSB-first priority encoder: index of the highest set bit, 0 with zero=1
// when the vector is all zeros.
module fp_lead_one_detector #(
    parameter int WIDTH = 25,
    parameter int POS_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    // Ascending scan: the last hit wins, which gives the MSB priority.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip the assignment infer a latch.
        pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) pos = POS_W'(i);
        end
    end

    assign zero = ~|vec;

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle control FSM for the single-precision adder datapath: steps the
// four stages one per cycle, latches their controls, and bypasses zero operands.
module fp_add_sequencer
    import fp_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = FP_DATA_WIDTH,
    parameter int MENT_WIDTH = FP_MENT_WIDTH,
    parameter int EXPO_WIDTH = FP_EXPO_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fp_add_sequencer_if.slave             hs,
    input  logic                          flush,
    input  logic [EXPO_WIDTH:0]           exp_diff_in,
    input  logic [MENT_WIDTH+1:0]         addition_in,
    output logic [3:0]                    stage_en_out,
    output logic                          mux1_sel_out,
    output logic                          mux2_sel_out,
    output logic                          mux3_sel_out,
    output logic [EXPO_WIDTH-1:0]         rshift_out,
    output logic [$clog2(MENT_WIDTH+2):0] normalize_position_out,
    output logic                          valid_bit_out,
    output logic                          bypass_out,
    output logic                          bypass_sel_out
);

    localparam int SUM_W = MENT_WIDTH + 2;
    localparam int POS_W = $clog2(SUM_W) + 1;
    localparam logic [EXPO_WIDTH:0] SHIFT_LIMIT = (EXPO_WIDTH + 1)'(SUM_W);

    state_t state, state_next;

    logic                  op1_zero, op2_zero, take_bypass;
    logic                  accept, capture_exp, capture_pos, release_result;
    logic [EXPO_WIDTH:0]   diff_mag;
    logic [EXPO_WIDTH-1:0] rshift_next;
    logic [POS_W-1:0]      lead_pos;
    logic                  sum_zero;
    logic                  mux_sel_q;
    logic                  unused_sign;

    // A zero is exponent = 0 and fraction = 0; the sign bit does not matter.
    assign op1_zero    = (hs.floating1_in[DATA_WIDTH-2:0] == '0);
    assign op2_zero    = (hs.floating2_in[DATA_WIDTH-2:0] == '0);
    assign take_bypass = op1_zero | op2_zero;
    assign unused_sign = hs.floating1_in[DATA_WIDTH-1] ^ hs.floating2_in[DATA_WIDTH-1];

    // |exp_diff| as unsigned; -(-2^EXPO_WIDTH) wraps to the same bit pattern, which is correct unsigned.
    always_comb begin
        diff_mag    = exp_diff_in[EXPO_WIDTH] ? -exp_diff_in : exp_diff_in;
        rshift_next = (diff_mag > SHIFT_LIMIT) ? SHIFT_LIMIT[EXPO_WIDTH-1:0]
                                               : diff_mag[EXPO_WIDTH-1:0];
    end

    fp_lead_one_detector #(
        .WIDTH (SUM_W),
        .POS_W (POS_W)
    ) u_lead_one (
        .vec  (addition_in),
        .pos  (lead_pos),
        .zero (sum_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Flush wins over everything, including a pending in_valid, and suppresses captures.
    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        capture_exp    = 1'b0;
        capture_pos    = 1'b0;
        release_result = 1'b0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (hs.in_valid) begin
                        accept     = 1'b1;
                        state_next = take_bypass ? DONE : EXP_CMP;
                    end
                end
                EXP_CMP: begin
                    capture_exp = 1'b1;
                    state_next  = ALIGN;
                end
                ALIGN:     state_next = MANT_ADD;
                MANT_ADD: begin
                    capture_pos = 1'b1;
                    state_next  = NORMALIZE;
                end
                NORMALIZE: state_next = DONE;
                DONE: begin
                    if (hs.out_ready) begin
                        release_result = 1'b1;
                        state_next     = IDLE;
                    end
                end
                default:   state_next = IDLE;
            endcase
        end
    end

    // Latched controls hold until the next capture; flush leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_sel_q              <= 1'b0;
            rshift_out             <= '0;
            normalize_position_out <= '0;
            valid_bit_out          <= 1'b0;
            bypass_out             <= 1'b0;
            bypass_sel_out         <= 1'b0;
        end else begin
            if (accept) begin
                bypass_out <= take_bypass;
                if (take_bypass) bypass_sel_out <= op1_zero;
            end
            if (capture_exp) begin
                mux_sel_q  <= ~exp_diff_in[EXPO_WIDTH];
                rshift_out <= rshift_next;
            end
            if (capture_pos) begin
                normalize_position_out <= lead_pos;
                valid_bit_out          <= ~sum_zero;
            end
            if (release_result) bypass_out <= 1'b0;
        end
    end

    assign mux1_sel_out = mux_sel_q;
    assign mux2_sel_out = mux_sel_q;
    assign mux3_sel_out = mux_sel_q;

    assign stage_en_out = stage_enable(state);
    assign hs.in_ready  = (state == IDLE);
    assign hs.out_valid = (state == DONE);

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Self-checking bench for fp_add_sequencer: a small model predicts the latched
// controls per operation into a scoreboard, compared when out_valid appears.
module tb_fp_add_sequencer;
    import fp_ctrl_pkg::*;

    typedef struct {
        logic                 mux;
        logic [7:0]           rshift;
        logic [POS_WIDTH-1:0] pos;
        logic                 valid;
        logic                 bypass;
        logic                 bsel;
        int                   latency;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flush = 1'b0;
    logic [8:0]           exp_diff = '0;
    logic [24:0]          addition = '0;
    logic [3:0]           stage_en;
    logic                 mux1, mux2, mux3;
    logic [7:0]           rshift;
    logic [POS_WIDTH-1:0] norm_pos;
    logic                 valid_bit, bypass, bypass_sel;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    logic                 m_mux = 1'b0;
    logic [7:0]           m_rshift = '0;
    logic [POS_WIDTH-1:0] m_pos = '0;
    logic                 m_valid = 1'b0;
    logic                 m_bsel = 1'b0;

    fp_add_sequencer_if #(.DATA_WIDTH(FP_DATA_WIDTH)) hs ();

    fp_add_sequencer dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .hs                     (hs),
        .flush                  (flush),
        .exp_diff_in            (exp_diff),
        .addition_in            (addition),
        .stage_en_out           (stage_en),
        .mux1_sel_out           (mux1),
        .mux2_sel_out           (mux2),
        .mux3_sel_out           (mux3),
        .rshift_out             (rshift),
        .normalize_position_out (norm_pos),
        .valid_bit_out          (valid_bit),
        .bypass_out             (bypass),
        .bypass_sel_out         (bypass_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_shift(input logic [8:0] ed);
        int d;
        d = int'($signed(ed));
        if (d < 0) d = -d;
        if (d > SHIFT_SAT) d = SHIFT_SAT;
        return 8'(d);
    endfunction

    function automatic void lead_one(input logic [24:0] v, output logic [POS_WIDTH-1:0] p,
                                     output logic vb);
        p  = '0;
        vb = 1'b0;
        for (int i = 24; i >= 0; i--) begin
            if (v[i]) begin
                p  = POS_WIDTH'(i);
                vb = 1'b1;
                break;
            end
        end
    endfunction

    function automatic void model_push(input logic [31:0] f1, input logic [31:0] f2,
                                       input logic [8:0] ed, input logic [24:0] ad);
        exp_t e;
        logic z1, z2;
        z1 = (f1[30:0] == 31'd0);
        z2 = (f2[30:0] == 31'd0);
        if (z1 || z2) begin
            m_bsel    = z1;
            e.bypass  = 1'b1;
            e.latency = 1;
        end else begin
            m_mux    = ~ed[8];
            m_rshift = exp_shift(ed);
            lead_one(ad, m_pos, m_valid);
            e.bypass  = 1'b0;
            e.latency = 5;
        end
        e.mux    = m_mux;
        e.rshift = m_rshift;
        e.pos    = m_pos;
        e.valid  = m_valid;
        e.bsel   = m_bsel;
        sb.push_back(e);
    endfunction

    task automatic check_reset_vals(input string tag);
        check($sformatf("%s_in_ready", tag), hs.in_ready, 1);
        check($sformatf("%s_out_valid", tag), hs.out_valid, 0);
        check($sformatf("%s_stage_en", tag), stage_en, 0);
        check($sformatf("%s_mux", tag), {mux1, mux2, mux3}, 0);
        check($sformatf("%s_rshift", tag), rshift, 0);
        check($sformatf("%s_pos", tag), norm_pos, 0);
        check($sformatf("%s_valid_bit", tag), valid_bit, 0);
        check($sformatf("%s_bypass", tag), {bypass, bypass_sel}, 0);
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check($sformatf("%s_out_valid", tag), hs.out_valid, 1);
        check($sformatf("%s_in_ready", tag), hs.in_ready, 0);
        check($sformatf("%s_stage_en", tag), stage_en, 0);
        check($sformatf("%s_mux", tag), {mux1, mux2, mux3}, {3{e.mux}});
        check($sformatf("%s_rshift", tag), rshift, e.rshift);
        check($sformatf("%s_pos", tag), norm_pos, e.pos);
        check($sformatf("%s_valid_bit", tag), valid_bit, e.valid);
        check($sformatf("%s_bypass", tag), bypass, e.bypass);
        check($sformatf("%s_bypass_sel", tag), bypass_sel, e.bsel);
    endtask

    task automatic drive_op(input logic [31:0] f1, input logic [31:0] f2,
                            input logic [8:0] ed, input logic [24:0] ad);
        hs.floating1_in = f1;
        hs.floating2_in = f2;
        exp_diff        = ed;
        addition        = ad;
        hs.in_valid     = 1'b1;
    endtask

    task automatic wait_accept(input string tag, input bit drop_valid);
        int n = 0;
        while (!hs.in_ready && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("%s_accept", tag), hs.in_ready, 1);
        tick();
        if (drop_valid) hs.in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] f1, input logic [31:0] f2,
                          input logic [8:0] ed, input logic [24:0] ad, input int hold);
        exp_t       e;
        int         k;
        bit         seen;
        logic [3:0] want;
        model_push(f1, f2, ed, ad);
        e = sb[0];
        hs.out_ready = (hold == 0);
        drive_op(f1, f2, ed, ad);
        wait_accept(tag, 1'b1);
        k    = 1;
        seen = 1'b0;
        while (!seen && k <= 20) begin
            if (hs.out_valid) begin
                seen = 1'b1;
            end else begin
                want = (e.bypass || k > 4) ? 4'b0000 : 4'(1 << (k - 1));
                check($sformatf("%s_stage%0d", tag, k), stage_en, want);
                tick();
                k++;
            end
        end
        check($sformatf("%s_seen", tag), seen, 1);
        check($sformatf("%s_latency", tag), k, e.latency);
        check_outputs(tag, e);
        for (int h = 0; h < hold; h++) begin
            drive_op(32'h0, 32'h3F80_0000, 9'h000, 25'h0);
            tick();
            check_outputs($sformatf("%s_hold%0d", tag, h), e);
        end
        hs.in_valid  = 1'b0;
        hs.out_ready = 1'b1;
        tick();
        check($sformatf("%s_release_ready", tag), hs.in_ready, 1);
        check($sformatf("%s_release_valid", tag), hs.out_valid, 0);
        check($sformatf("%s_release_bypass", tag), bypass, 0);
        void'(sb.pop_front());
        hs.out_ready = 1'b0;
    endtask

    initial begin
        int p1, p2;
        exp_t e;
        hs.in_valid     = 1'b0;
        hs.out_ready    = 1'b0;
        hs.floating1_in = '0;
        hs.floating2_in = '0;
        #2;
        check_reset_vals("rst");
        #10;
        rst_n = 1'b1;
        tick();
        check_reset_vals("idle");

        // Normal path: negative, positive, saturated and -256 exponent differences.
        run_op("op_neg1", 32'h3FC0_0000, 32'h4000_0000, 9'h1FF, 25'h0E0_0000, 0);
        run_op("op_pos23", 32'h4B00_0000, 32'h3F80_0000, 9'h017, 25'h180_0000, 0);
        run_op("op_sat30", 32'h4B00_0000, 32'h3F80_0000, 9'h01E, 25'h000_0001, 0);
        run_op("op_m256", 32'h3F80_0000, 32'h7F00_0000, 9'h100, 25'h040_0000, 0);

        // Bypass: floating1 zero, floating2 negative zero, both zero.
        run_op("byp_f1", 32'h0000_0000, 32'h4049_0FDB, 9'h055, 25'h1FF_FFFF, 0);
        run_op("byp_f2", 32'h3F80_0000, 32'h8000_0000, 9'h055, 25'h1FF_FFFF, 0);
        run_op("byp_both", 32'h8000_0000, 32'h0000_0000, 9'h055, 25'h1FF_FFFF, 0);

        // Zero sum, result held with out_ready low while a new request waits.
        run_op("zero_sum", 32'h4000_0000, 32'h4000_0000, 9'h000, 25'h0, 5);

        // flush beats in_valid in IDLE.
        drive_op(32'h4000_0000, 32'h4000_0000, 9'h003, 25'h0);
        flush = 1'b1;
        tick();
        flush       = 1'b0;
        hs.in_valid = 1'b0;
        check("flush_idle_ready", hs.in_ready, 1);
        check("flush_idle_stage", stage_en, 0);

        // flush during ALIGN: the EXP_CMP captures stay, position is untouched.
        drive_op(32'h4000_0000, 32'h3F00_0000, 9'h1FC, 25'h000_0010);
        m_mux    = 1'b0;
        m_rshift = 8'd4;
        wait_accept("flush_op", 1'b1);
        tick();
        check("flush_align_stage", stage_en, 4'b0010);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ready", hs.in_ready, 1);
        check("flush_stage", stage_en, 0);
        check("flush_valid", hs.out_valid, 0);
        check("flush_kept_mux", {mux1, mux2, mux3}, {3{m_mux}});
        check("flush_kept_rshift", rshift, m_rshift);
        check("flush_kept_pos", norm_pos, m_pos);
        // A bypass afterwards exposes the retained controls through the scoreboard.
        run_op("after_flush", 32'h0000_0000, 32'h4000_0000, 9'h000, 25'h0, 0);

        // Back-to-back with in_valid held and out_ready high.
        model_push(32'h4100_0000, 32'h4000_0000, 9'h005, 25'h0A0_0000);
        model_push(32'h4100_0000, 32'h4000_0000, 9'h005, 25'h0A0_0000);
        hs.out_ready = 1'b1;
        drive_op(32'h4100_0000, 32'h4000_0000, 9'h005, 25'h0A0_0000);
        wait_accept("b2b", 1'b0);
        p1 = -1;
        p2 = -1;
        for (int k = 1; k <= 14; k++) begin
            if (hs.out_valid) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_outputs($sformatf("b2b_k%0d", k), e);
                end else begin
                    check($sformatf("b2b_extra_k%0d", k), hs.out_valid, 0);
                end
                if (p1 < 0) p1 = k;
                else if (p2 < 0) p2 = k;
            end
            if (k == 6) check("b2b_idle_ready", hs.in_ready, 1);
            if (k == 7) hs.in_valid = 1'b0;
            tick();
        end
        check("b2b_first", p1, 5);
        check("b2b_second", p2, 11);
        hs.out_ready = 1'b0;

        // Asynchronous reset in the middle of MANT_ADD.
        drive_op(32'h4000_0000, 32'h4040_0000, 9'h002, 25'h100_0000);
        wait_accept("rst_op", 1'b1);
        tick();
        tick();
        check("rst_mant_stage", stage_en, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        m_mux    = 1'b0;
        m_rshift = '0;
        m_pos    = '0;
        m_valid  = 1'b0;
        m_bsel   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset_vals("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
